// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: operation encoding,
// accepted-request record and FSM states.
package muldiv_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MUL   = 4'd8
    } md_op_t;

    localparam int MD_DIV_STEPS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Operands captured at accept; execute may move on once stall drops.
    typedef struct packed {
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi_acc;
        logic [31:0] lo_acc;
    } md_req_t;

    function automatic logic op_is_div(input md_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) ||
               (op == OP_MSUB) || (op == OP_MUL);
    endfunction

    function automatic logic op_is_madd(input md_op_t op);
        return (op == OP_MADD) || (op == OP_MADDU);
    endfunction

    function automatic logic op_is_msub(input md_op_t op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Radix-2 restoring divider datapath on unsigned magnitudes; one quotient
// bit is produced per enabled cycle, MSB first.
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [33:0] diff;

    // Extra top bit on diff keeps the borrow visible for 33-bit partials.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (en) begin
            if (diff[33]) begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end else begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: accepts one op from execute, stalls while
// the multiply or iterative divide runs, then strobes the result for one cycle.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  md_op_t      op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_acc,
    input  logic [31:0] lo_acc,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    md_state_t   state, state_n;
    logic [4:0]  cnt, cnt_n;
    md_req_t     req;
    logic [63:0] mul_q;
    logic        accept;
    logic        div_load;
    logic        div_en;

    logic        src_sgn;
    logic [31:0] abs_a, abs_b;
    logic [31:0] quo, rem;
    logic [31:0] quo_fix, rem_fix;
    logic [63:0] ext_a, ext_b, prod, mul_res;
    logic [63:0] result;
    logic        in_done;

    // Magnitudes are taken from the live operands so the divider loads at accept.
    always_comb begin
        src_sgn = op_is_signed(op);
        abs_a   = (src_sgn && src_a[31]) ? -src_a : src_a;
        abs_b   = (src_sgn && src_b[31]) ? -src_b : src_b;
    end

    div_iter u_div (
        .clk      (clk),
        .resetn   (resetn),
        .load     (div_load),
        .en       (div_en),
        .dividend (abs_a),
        .divisor  (abs_b),
        .quotient (quo),
        .remainder(rem)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        accept   = 1'b0;
        div_load = 1'b0;
        div_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept = 1'b1;
                    if (op_is_div(op)) begin
                        if (src_b == 32'd0) begin
                            state_n = DONE;
                        end else begin
                            state_n  = DIV;
                            cnt_n    = 5'(MD_DIV_STEPS - 1);
                            div_load = 1'b1;
                        end
                    end else begin
                        state_n = MUL;
                        cnt_n   = 5'(MUL_LAT - 1);
                    end
                end
            end
            MUL: begin
                cnt_n = cnt - 5'd1;
                if (cnt == 5'd0) begin
                    state_n = DONE;
                    cnt_n   = 5'd0;
                end
            end
            DIV: begin
                div_en = 1'b1;
                cnt_n  = cnt - 5'd1;
                if (cnt == 5'd0) begin
                    state_n = DONE;
                    cnt_n   = 5'd0;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
            cnt_n   = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            req   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                req.op     <= op;
                req.a      <= src_a;
                req.b      <= src_b;
                req.hi_acc <= hi_acc;
                req.lo_acc <= lo_acc;
            end
        end
    end

    // Sign/zero extension to 64 bits gives the right product mod 2^64 for both forms.
    always_comb begin
        ext_a   = op_is_signed(req.op) ? {{32{req.a[31]}}, req.a} : {32'd0, req.a};
        ext_b   = op_is_signed(req.op) ? {{32{req.b[31]}}, req.b} : {32'd0, req.b};
        prod    = ext_a * ext_b;
        mul_res = prod;
        if (op_is_madd(req.op))
            mul_res = {req.hi_acc, req.lo_acc} + prod;
        else if (op_is_msub(req.op))
            mul_res = {req.hi_acc, req.lo_acc} - prod;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            mul_q <= '0;
        else if (state == MUL)
            mul_q <= mul_res;
    end

    always_comb begin
        quo_fix = (op_is_signed(req.op) && (req.a[31] ^ req.b[31])) ? -quo : quo;
        rem_fix = (op_is_signed(req.op) && req.a[31]) ? -rem : rem;
        if (!op_is_div(req.op))
            result = mul_q;
        else if (req.b == 32'd0)
            result = {req.a, 32'hFFFF_FFFF};
        else
            result = {rem_fix, quo_fix};
    end

    // A flush in DONE kills the strobe in the same cycle.
    always_comb begin
        in_done = (state == DONE) && !flush;
        stall   = ((state == IDLE) && start && !flush) || (state == MUL) || (state == DIV);
        done    = in_done;
        hi_we   = in_done && (req.op != OP_MUL);
        lo_we   = in_done && (req.op != OP_MUL);
        hi_out  = in_done ? result[63:32] : 32'd0;
        lo_out  = in_done ? result[31:0]  : 32'd0;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops push expected results,
// a monitor pops and compares on every done strobe.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    md_op_t      op = OP_MULT;
    logic [31:0] src_a = '0, src_b = '0, hi_acc = '0, lo_acc = '0;
    logic        flush = 1'b0;
    logic        stall, done, hi_we, lo_we;
    logic [31:0] hi_out, lo_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        we;
        int          acc_cyc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sbq[$];

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_acc(hi_acc), .lo_acc(lo_acc),
        .flush(flush), .stall(stall), .done(done), .hi_we(hi_we), .lo_we(lo_we),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: sample mid-cycle, away from both clock edges.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = sbq.pop_front();
                check({e.name, "_hi"}, 64'(hi_out), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo_out), 64'(e.lo));
                check({e.name, "_hi_we"}, 64'(hi_we), 64'(e.we));
                check({e.name, "_lo_we"}, 64'(lo_we), 64'(e.we));
                check({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end else begin
            check("idle_outputs", {30'd0, hi_we, lo_we, hi_out | lo_out}, 64'(0));
        end
    end

    task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ha, input logic [31:0] la,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic ewe, input int lat, input string nm);
        exp_t e;
        int   n;
        @(negedge clk);
        op = o; src_a = a; src_b = b; hi_acc = ha; lo_acc = la; start = 1'b1;
        e.hi = ehi; e.lo = elo; e.we = ewe; e.acc_cyc = cyc; e.lat = lat; e.name = nm;
        sbq.push_back(e);
        #1;
        check({nm, "_accept_stall"}, 64'(stall), 64'(1));
        n = 1;
        forever begin
            @(negedge clk);
            #1;
            if (!stall) break;
            n++;
            if (n > 100) break;
        end
        check({nm, "_stall_cycles"}, 64'(n), 64'(lat));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {29'd0, stall, done, hi_we, lo_we}, 64'(0));
        check("reset_data", {hi_out, lo_out}, 64'(0));
        @(negedge clk) resetn = 1'b1;

        issue(OP_MULT,  32'hFFFF_FFFD, 32'd5, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 3,  "mult_neg");
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 3, "multu_max");
        issue(OP_DIVU,  32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 1'b1, 33, "divu_100_7");
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 33, "div_m7_2");
        issue(OP_DIV,   32'h0000_1234, 32'd0, 0, 0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1,  "div_by_zero");
        issue(OP_DIVU,  32'd5, 32'd0, 0, 0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, "divu_by_zero");
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 32'h8000_0000, 1'b1, 33, "div_ovf");
        issue(OP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 3, "maddu_carry");
        issue(OP_MSUB,  32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3, "msub_wrap");
        issue(OP_MUL,   32'd6, 32'd7, 0, 0, 32'd0, 32'd42, 1'b0, 3, "mul_gpr");

        // start was held through DONE: exactly one strobe, idle afterwards
        @(negedge clk);
        #1;
        check("single_done_queue", 64'(sbq.size()), 64'(0));
        check("idle_after_done_stall", 64'(stall), 64'(0));

        // flush at cycle 10 of a divide
        @(negedge clk);
        op = OP_DIV; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; start = 1'b0;
        #1;
        check("flush_stall", 64'(stall), 64'(0));
        check("flush_done", 64'(done), 64'(0));
        issue(OP_MULT, 32'd3, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 3, "mult_after_flush");

        // reset at cycle 5 of a divide
        @(negedge clk);
        op = OP_DIVU; src_a = 32'd77; src_b = 32'd5; start = 1'b1;
        repeat (5) @(negedge clk);
        resetn = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_ctrl", {29'd0, stall, done, hi_we, lo_we}, 64'(0));
        check("midreset_data", {hi_out, lo_out}, 64'(0));
        @(negedge clk) resetn = 1'b1;
        issue(OP_DIVU, 32'd77, 32'd5, 0, 0, 32'd2, 32'd15, 1'b1, 33, "divu_after_reset");

        repeat (5) @(negedge clk);
        #2;
        check("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
